// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the 2-bit adder stage, the result accumulator
// and the consumer of finished burst totals. The slave side is the
// accumulator. The master side drives samples, clear and out_ready.
interface adder_result_accumulator_if #(
    parameter int ACC_WIDTH = 8,
    parameter int CNT_WIDTH = 3
);
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_sum;
    logic                 in_carry;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_total;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_overflow;

    modport master (
        output clear, in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_total, out_count, out_overflow
    );

    modport slave (
        input  clear, in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_total, out_count, out_overflow
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Accumulates BURST_LEN {carry, sum} adder results (0..6 each) into a
// running total. Presents the total with valid/ready and a sticky overflow
// flag. Stalls the producer while a finished total waits for pickup.
// Parameter constraints: ACC_WIDTH >= 3, BURST_LEN >= 1,
// and 2**CNT_WIDTH > BURST_LEN.
module adder_result_accumulator #(
    parameter int ACC_WIDTH = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    adder_result_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic [ACC_WIDTH-1:0] sample_s;
    logic [ACC_WIDTH:0]   sum_ext_s;
    logic [CNT_WIDTH-1:0] count_inc_s;
    logic                 accept_s;
    logic                 handshake_s;

    // Sample extension, extended-width add and the two handshake events.
    always_comb begin
        sample_s    = ACC_WIDTH'({bus.in_carry, bus.in_sum});
        sum_ext_s   = {1'b0, acc_q} + {1'b0, sample_s};
        count_inc_s = count_q + ONE_CNT;
        accept_s    = bus.in_valid && in_ready_q;
        handshake_s = out_valid_q && bus.out_ready;
    end

    // Next-state logic. clear overrides any accept or handshake in the same cycle.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.clear) begin
            state_d    = ST_IDLE;
            acc_d      = {ACC_WIDTH{1'b0}};
            count_d    = {CNT_WIDTH{1'b0}};
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        // acc is zero here, so this is the sample itself.
                        acc_d      = sum_ext_s[ACC_WIDTH-1:0];
                        overflow_d = sum_ext_s[ACC_WIDTH];
                        count_d    = ONE_CNT;
                        state_d    = (BURST_CNT == ONE_CNT) ? ST_DONE : ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_d      = sum_ext_s[ACC_WIDTH-1:0];
                        overflow_d = overflow_q | sum_ext_s[ACC_WIDTH];
                        count_d    = count_inc_s;
                        state_d    = (count_inc_s == BURST_CNT) ? ST_DONE : ST_ACCUM;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (handshake_s) begin
                        state_d    = ST_IDLE;
                        acc_d      = {ACC_WIDTH{1'b0}};
                        count_d    = {CNT_WIDTH{1'b0}};
                        overflow_d = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    acc_d      = {ACC_WIDTH{1'b0}};
                    count_d    = {CNT_WIDTH{1'b0}};
                    overflow_d = 1'b0;
                end
            endcase
        end
    end

    // Handshake flags follow the next state, so they are registered copies of
    // state. in_ready therefore never depends on in_valid.
    always_comb begin
        in_ready_d  = (state_d != ST_DONE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and handshake registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= {ACC_WIDTH{1'b0}};
            count_q     <= {CNT_WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_total    = acc_q;
    assign bus.out_count    = count_q;
    assign bus.out_overflow = overflow_q;

endmodule
